// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite ROM arbiter.
//   REQ_*       requester indices into req/gnt/rvalid
//   NUM_REQ     number of pixel-fetch requesters
//   pixel_t     RGB888 pixel
//   TRANSP_KEY  colour that marks a transparent pixel
//   rd_tag_t    one return-pipe entry {valid, one-hot requester tag}
//   next_ptr()  round-robin pointer successor with wrap
package sprite_pkg;

    localparam int REQ_FIREBOY   = 0;
    localparam int REQ_WATERGIRL = 1;
    localparam int REQ_WALL      = 2;
    localparam int NUM_REQ       = 3;

    typedef logic [23:0] pixel_t;

    localparam pixel_t TRANSP_KEY = 24'h800080;

    typedef struct packed {
        logic               v;
        logic [NUM_REQ-1:0] tag;
    } rd_tag_t;

    function automatic int next_ptr(input int winner, input int n);
        return (winner >= n - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Round-robin request selector, purely combinational.
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   PTR_W    index searched first
//   gnt     out  NUM_REQ  one-hot winner, zero when no request
//   winner  out  PTR_W    index of the winner, 0 when no request
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner
);

    logic found;
    int   idx;

    // Walk the requesters starting at rr_ptr; the first set bit wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite memory between the per-pixel fetch
// units, with round-robin arbitration and a tagged fixed-latency return.
//   Clk        in   1               system clock
//   Reset      in   1               asynchronous active-high reset
//   req        in   NUM_REQ         per-requester read request (level)
//   req_addr   in   NUM_REQ*ADDR_W  per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//   gnt        out  NUM_REQ         one-hot grant, same cycle as the accepted request
//   mem_rd     out  1               memory read strobe
//   mem_addr   out  ADDR_W          memory address of the granted requester
//   mem_rdata  in   DATA_W          memory data, RD_LAT cycles after mem_rd
//   rvalid     out  NUM_REQ         one-hot return strobe
//   rdata      out  DATA_W          returned pixel, holds when rvalid=0
//   rtransp    out  1               returned pixel equals TRANSP_KEY
module sprite_rom_arbiter #(
    parameter int                 NUM_REQ    = 3,
    parameter int                 ADDR_W     = 14,
    parameter int                 DATA_W     = 24,
    parameter int                 RD_LAT     = 1,
    parameter logic [DATA_W-1:0]  TRANSP_KEY = 24'h800080
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rtransp
);

    import sprite_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]               rr_ptr;
    logic [NUM_REQ-1:0]             arb_gnt;
    logic [PTR_W-1:0]               winner;
    logic [RD_LAT-1:0]              pipe_v;
    logic [RD_LAT-1:0][NUM_REQ-1:0] pipe_tag;
    logic                           tail_v;
    logic [NUM_REQ-1:0]             tail_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .winner  (winner)
    );

    // No grant may escape while the block is held in reset, otherwise a
    // requester would consider its transfer done and never re-issue.
    assign gnt    = Reset ? '0 : arb_gnt;
    assign mem_rd = |gnt;

    always_comb begin
        mem_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr <= '0;
        end else if (mem_rd) begin
            rr_ptr <= PTR_W'(next_ptr(int'(winner), NUM_REQ));
        end
    end

    // Return pipe runs in lockstep with the memory read latency, so the
    // tail entry lines up with mem_rdata of the same read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pipe_v   <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_v[0]   <= mem_rd;
            pipe_tag[0] <= gnt;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_v[s]   <= pipe_v[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    assign tail_v   = pipe_v[RD_LAT-1];
    assign tail_tag = pipe_tag[RD_LAT-1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rvalid  <= '0;
            rdata   <= '0;
            rtransp <= 1'b0;
        end else begin
            rvalid  <= tail_v ? tail_tag : '0;
            rtransp <= tail_v && (mem_rdata == TRANSP_KEY);
            if (tail_v) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [2:0]  req;
    logic [41:0] req_addr;

    logic [2:0]  gnt1, gnt3, rvalid1, rvalid3;
    logic        mem_rd1, mem_rd3, rtransp1, rtransp3;
    logic [13:0] mem_addr1, mem_addr3;
    logic [23:0] mem_rdata1, mem_rdata3, rdata1, rdata3;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter #(.RD_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr),
        .gnt(gnt1), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .rvalid(rvalid1), .rdata(rdata1), .rtransp(rtransp1)
    );

    sprite_rom_arbiter #(.RD_LAT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr),
        .gnt(gnt3), .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
        .rvalid(rvalid3), .rdata(rdata3), .rtransp(rtransp3)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [23:0] memf(input logic [13:0] a);
        if (a == 14'h0123) return TRANSP_KEY;
        if (a == 14'h0124) return 24'h00FF00;
        if (a[3:0] == 4'hF) return TRANSP_KEY;
        return {a[7:0] ^ 8'hA5, a[13:6], a[5:0], 2'b11};
    endfunction

    logic [23:0] m1;
    logic [23:0] m3 [3];
    always @(posedge Clk) begin
        m1    <= memf(mem_addr1);
        m3[0] <= memf(mem_addr3);
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign mem_rdata1 = m1;
    assign mem_rdata3 = m3[2];

    typedef struct {
        int          due;
        logic [2:0]  tag;
        logic [23:0] data;
    } ret_t;

    ret_t q1[$];
    ret_t q3[$];
    int   cyc = 0;
    int   ptr = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [41:0] pack(input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic check_returns();
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("rvalid1", 32'(rvalid1), 32'(q1[0].tag));
            chk("rdata1", 32'(rdata1), 32'(q1[0].data));
            chk("rtransp1", 32'(rtransp1), 32'(q1[0].data == TRANSP_KEY));
            void'(q1.pop_front());
        end else begin
            chk("rvalid1_idle", 32'(rvalid1), 32'd0);
            chk("rtransp1_idle", 32'(rtransp1), 32'd0);
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            chk("rvalid3", 32'(rvalid3), 32'(q3[0].tag));
            chk("rdata3", 32'(rdata3), 32'(q3[0].data));
            chk("rtransp3", 32'(rtransp3), 32'(q3[0].data == TRANSP_KEY));
            void'(q3.pop_front());
        end else begin
            chk("rvalid3_idle", 32'(rvalid3), 32'd0);
            chk("rtransp3_idle", 32'(rtransp3), 32'd0);
        end
    endtask

    // One clock cycle: check registered outputs, apply inputs, check the
    // combinational grant path and update the reference model.
    task automatic step(input logic rst, input logic [2:0] r, input logic [41:0] a,
                        output logic [2:0] g);
        int          w;
        int          idx;
        logic [2:0]  eg;
        logic [13:0] ea;
        @(negedge Clk);
        cyc++;
        check_returns();
        Reset    = rst;
        req      = r;
        req_addr = a;
        #1;
        w  = -1;
        eg = 3'b000;
        ea = 14'h0;
        if (rst) begin
            q1.delete();
            q3.delete();
            ptr = 0;
            chk("rst_rvalid1", 32'(rvalid1), 32'd0);
            chk("rst_rvalid3", 32'(rvalid3), 32'd0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                idx = (ptr + k) % 3;
                if (w < 0 && r[idx]) w = idx;
            end
        end
        if (w >= 0) begin
            eg = 3'(1 << w);
            ea = a[w*14 +: 14];
        end
        chk("gnt1", 32'(gnt1), 32'(eg));
        chk("gnt3", 32'(gnt3), 32'(eg));
        chk("gnt_onehot0", 32'($onehot0(gnt1)), 32'd1);
        chk("mem_rd1", 32'(mem_rd1), 32'(w >= 0));
        chk("mem_rd3", 32'(mem_rd3), 32'(w >= 0));
        chk("mem_addr1", 32'(mem_addr1), 32'(ea));
        chk("mem_addr3", 32'(mem_addr3), 32'(ea));
        if (w >= 0) begin
            q1.push_back('{due: cyc + 2, tag: eg, data: memf(ea)});
            q3.push_back('{due: cyc + 4, tag: eg, data: memf(ea)});
            ptr = (w + 1) % 3;
        end
        g = gnt1;
    endtask

    logic [2:0]  g;
    logic [2:0]  burst [3];
    logic        pend [3];
    logic [13:0] ha [3];
    int          wait_c [3];
    logic [2:0]  r;

    initial begin
        Reset    = 1'b1;
        req      = 3'b000;
        req_addr = '0;

        // Reset held with all requesting: nothing granted or returned.
        step(1'b1, 3'b111, pack(14'h0050, 14'h0100, 14'h0200), g);
        step(1'b1, 3'b111, pack(14'h0050, 14'h0100, 14'h0200), g);
        chk("t1_gnt_in_reset", 32'(g), 32'd0);

        // Release: rotation 0,1,2,0,1,2 with all requests held.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b111, pack(14'h0050 + 14'(i), 14'h0100 + 14'(i), 14'h0200 + 14'(i)), g);
            chk("t2_rotate", 32'(g), 32'(3'b001 << (i % 3)));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, '0, g);

        // Wall only: transparent and opaque pixels.
        step(1'b0, 3'b100, pack(14'h0, 14'h0, 14'h0123), g);
        chk("t3_gnt", 32'(g), 32'b100);
        step(1'b0, 3'b000, '0, g);
        step(1'b0, 3'b100, pack(14'h0, 14'h0, 14'h0124), g);
        chk("t3_rvalid", 32'(rvalid1), 32'b100);
        chk("t3_rdata", 32'(rdata1), 32'h800080);
        chk("t3_rtransp", 32'(rtransp1), 32'd1);
        step(1'b0, 3'b000, '0, g);
        step(1'b0, 3'b000, '0, g);
        chk("t3b_rvalid", 32'(rvalid1), 32'b100);
        chk("t3b_rdata", 32'(rdata1), 32'h00FF00);
        chk("t3b_rtransp", 32'(rtransp1), 32'd0);
        step(1'b0, 3'b000, '0, g);
        chk("t3_hold_rdata", 32'(rdata1), 32'h00FF00);

        // Pointer wrap: grant 1 leaves pointer at 2, then 011 wraps to 0.
        step(1'b0, 3'b010, pack(14'h0011, 14'h0022, 14'h0), g);
        chk("t4_setup", 32'(g), 32'b010);
        step(1'b0, 3'b011, pack(14'h0011, 14'h0022, 14'h0), g);
        chk("t4_wrap", 32'(g), 32'b001);
        step(1'b0, 3'b011, pack(14'h0011, 14'h0022, 14'h0), g);
        chk("t4_next", 32'(g), 32'b010);
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, '0, g);

        // RD_LAT=3: three grants return four cycles later, in order.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b111, pack(14'h0300, 14'h0301, 14'h0302), g);
            burst[i] = g;
        end
        step(1'b0, 3'b000, '0, g);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b000, '0, g);
            chk("t5_rvalid3", 32'(rvalid3), 32'(burst[i]));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111, pack(14'h0400, 14'h0401, 14'h0402), g);
        step(1'b1, 3'b000, '0, g);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b000, '0, g);
            chk("t5_killed_rvalid3", 32'(rvalid3), 32'd0);
            chk("t5_killed_rvalid1", 32'(rvalid1), 32'd0);
        end

        // Randomised traffic with the hold-until-granted handshake.
        for (int i = 0; i < 3; i++) begin
            pend[i]   = 1'b0;
            ha[i]     = '0;
            wait_c[i] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            r = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(99) < 60) begin
                        pend[i]   = 1'b1;
                        ha[i]     = 14'($urandom);
                        wait_c[i] = 0;
                    end
                end else if ($urandom_range(99) < 3) begin
                    pend[i] = 1'b0;
                end
                r[i] = pend[i];
            end
            step(1'b0, r, pack(ha[0], ha[1], ha[2]), g);
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    if (g[i]) begin
                        chk("max_wait", 32'(wait_c[i] <= 2), 32'd1);
                        pend[i] = 1'b0;
                    end else begin
                        wait_c[i]++;
                    end
                end
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 3'b000, '0, g);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
